// File: rtl/mem_responder_pkg.sv
// Shared constants, FSM state encoding and write-buffer entry type for the
// memory responder and its posted-write buffer.
package mem_responder_pkg;

  localparam logic [31:0] FAST_BASE  = 32'hFFFF_1000;
  localparam logic [31:0] FAST_LIMIT = 32'hFFFF_107F;
  localparam logic [31:0] PAGE_ADDR  = 32'hFFFF_1010;
  localparam logic [31:0] SP_ADDR    = 32'hFFFF_100F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    RREQ  = 2'd2,
    RDONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] data;
  } wbuf_entry_t;

  function automatic logic is_fast(input logic [31:0] addr);
    return (addr >= FAST_BASE) && (addr <= FAST_LIMIT);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side and external-memory-side signal bundle of the memory responder.
// The responder uses the slave view; the CPU/memory environment the master view.
interface mem_responder_if;
  logic [31:0] memAddr;
  logic [15:0] memWrite;
  logic        memRE;
  logic        memWE;
  logic [15:0] memReadIn;
  logic        memReady;
  logic [15:0] page;
  logic [31:0] ext_addr;
  logic [15:0] ext_wdata;
  logic        ext_we;
  logic        ext_req;
  logic        ext_ack;
  logic [15:0] ext_rdata;
  logic        wbuf_ovf;

  modport slave (
    input  memAddr, memWrite, memRE, memWE, ext_ack, ext_rdata,
    output memReadIn, memReady, page, ext_addr, ext_wdata, ext_we, ext_req, wbuf_ovf
  );

  modport master (
    output memAddr, memWrite, memRE, memWE, ext_ack, ext_rdata,
    input  memReadIn, memReady, page, ext_addr, ext_wdata, ext_we, ext_req, wbuf_ovf
  );
endinterface

// File: rtl/mem_responder_wbuf.sv
// Posted-write FIFO: head entry is visible combinationally, and a push into a
// full buffer succeeds when a pop happens in the same cycle.
module mem_wbuf
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  wbuf_entry_t   i_data,
  output wbuf_entry_t   o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  wbuf_entry_t   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_do_push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // When full with a simultaneous pop, the write slot is the head being retired.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/mem_responder.sv
// CPU memory responder: single-cycle fast region with page/SP special words,
// posted external writes, and ordered external reads behind the write buffer.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WBUF_DEPTH = 4,
  parameter int FAST_WORDS = 128
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam int AW = $clog2(FAST_WORDS);
  localparam int CW = $clog2(WBUF_DEPTH + 1);

  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_mem [FAST_WORDS];
  logic [15:0]   r_page;
  logic [15:0]   r_rdata;
  logic          r_ovf;

  logic          w_fast;
  logic          w_is_page;
  logic          w_is_sp;
  logic          w_wr_ok;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [AW-1:0] w_idx;
  logic [15:0]   w_fast_rd;
  wbuf_entry_t   w_head;
  wbuf_entry_t   w_entry;

  assign w_fast    = is_fast(bus.memAddr);
  assign w_is_page = (bus.memAddr == PAGE_ADDR);
  assign w_is_sp   = (bus.memAddr == SP_ADDR);
  assign w_idx     = bus.memAddr[AW-1:0];
  // Writes are taken only in IDLE so a write held during a read stall is not repeated.
  assign w_wr_ok   = bus.memWE && (r_state == IDLE);
  assign w_push    = w_wr_ok && !w_fast;
  assign w_entry   = '{addr: bus.memAddr, data: bus.memWrite};

  mem_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_entry),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // A same-cycle write forwards its data so the read observes the write first.
  always_comb begin
    if (w_is_sp)        w_fast_rd = 16'h0000;
    else if (w_wr_ok)   w_fast_rd = bus.memWrite;
    else if (w_is_page) w_fast_rd = r_page;
    else                w_fast_rd = r_mem[w_idx];
  end

  always_comb begin
    w_next        = r_state;
    w_pop         = 1'b0;
    bus.memReady  = 1'b0;
    bus.memReadIn = 16'h0000;
    bus.ext_req   = 1'b0;
    bus.ext_we    = 1'b0;
    bus.ext_addr  = 32'h0000_0000;
    bus.ext_wdata = 16'h0000;
    case (r_state)
      IDLE, DRAIN: begin
        if (!w_empty) begin
          bus.ext_req   = 1'b1;
          bus.ext_we    = 1'b1;
          bus.ext_addr  = w_head.addr;
          bus.ext_wdata = w_head.data;
          w_pop         = bus.ext_ack;
        end
        if (r_state == IDLE) begin
          if (bus.memRE && w_fast) begin
            bus.memReady  = 1'b1;
            bus.memReadIn = w_fast_rd;
          end else if (bus.memRE) begin
            w_next = (!w_empty || w_push) ? DRAIN : RREQ;
          end
        end else if (w_count == '0) begin
          w_next = RREQ;
        end
      end
      RREQ: begin
        bus.ext_req  = 1'b1;
        bus.ext_addr = bus.memAddr;
        if (bus.ext_ack) w_next = RDONE;
      end
      RDONE: begin
        if (bus.memRE) begin
          bus.memReady  = 1'b1;
          bus.memReadIn = r_rdata;
        end
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_page  <= 16'h0000;
      r_ovf   <= 1'b0;
      r_rdata <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (w_wr_ok && w_is_page)          r_page  <= bus.memWrite;
      if (w_push && w_full && !w_pop)    r_ovf   <= 1'b1;
      if (r_state == RREQ && bus.ext_ack) r_rdata <= bus.ext_rdata;
    end
  end

  // Fast array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok && w_fast && !w_is_page && !w_is_sp) r_mem[w_idx] <= bus.memWrite;
  end

  assign bus.page     = r_page;
  assign bus.wbuf_ovf = r_ovf;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameters: WBUF_DEPTH, default 4, posted-write buffer entries; FAST_WORDS, default 128, fast-memory words.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have CPU-side inputs: memAddr (32, word address), memWrite (16, write data), memRE (1), memWE (1).
REQ-005 SHALL have CPU-side outputs: memReadIn (16, read data), memReady (1, read complete), page (16, page register).
REQ-006 SHALL have external-memory outputs: ext_addr (32), ext_wdata (16), ext_we (1, 1=write / 0=read), ext_req (1).
REQ-007 SHALL have external-memory inputs ext_ack (1) and ext_rdata (16); ext_rdata is valid only in the ext_ack cycle.
REQ-008 SHALL have output wbuf_ovf (1): sticky posted-write overflow error.

Function
REQ-009 Fast region SHALL be 0xFFFF1000-0xFFFF107F, indexed by memAddr[6:0]; every other address SHALL be external.
REQ-010 Fast reads SHALL be combinational: memReadIn = array word and memReady=1 in the same cycle memRE is high.
REQ-011 A fast write SHALL update the array at the clock edge where memWE is high.
REQ-012 Address 0xFFFF1010 SHALL be the page register: writes load page, and reads return page.
REQ-013 Writes to 0xFFFF100F SHALL be discarded, and reads of it SHALL return 0x0000 (the CPU substitutes SP there).
REQ-014 External writes SHALL be posted: {memAddr, memWrite} is enqueued in the write buffer in the memWE cycle, and memReady is not involved.
REQ-015 An external write arriving while the buffer is full SHALL be dropped and SHALL set wbuf_ovf; wbuf_ovf clears only on reset.
REQ-016 The buffer SHALL drain in order: ext_req=1, ext_we=1, ext_addr/ext_wdata from the head entry, held stable until ext_ack; the entry is dequeued in the ack cycle.
REQ-017 An enqueue and a dequeue in the same cycle SHALL both take effect, with count unchanged, even when the buffer is full.
REQ-018 The FSM SHALL have states IDLE, DRAIN, RREQ and RDONE.
REQ-019 IDLE: with the buffer non-empty, memRE low or fast, the FSM SHALL drain writes in the background.
REQ-020 IDLE: on an external memRE, the FSM SHALL go to DRAIN if the buffer is non-empty, otherwise to RREQ; memReady=0.
REQ-021 DRAIN: the FSM SHALL empty the buffer (reads never bypass writes) and then go to RREQ; memReady=0.
REQ-022 RREQ: ext_req=1, ext_we=0, ext_addr=memAddr; on ext_ack, ext_rdata SHALL be latched and the FSM SHALL go to RDONE; memReady=0.
REQ-023 RDONE: memReady=1 and memReadIn=latched data for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-024 Minimum external read latency with the buffer empty and ack one cycle after req SHALL be 3 cycles (memRE through memReady).
REQ-025 memRE and memWE high together SHALL first enqueue or perform the write, then service the read; ordering SHALL hold for a read of the same address.
REQ-026 The CPU holds memAddr/memRE stable while memReady=0; the responder SHALL sample memAddr live in RREQ.
REQ-027 memReady SHALL be 0 whenever memRE=0; memReadIn SHALL be 0x0000 when memReady=0.
REQ-028 Back-to-back requests SHALL be accepted in the cycle after RDONE with no idle cycle required.

Reset
REQ-029 On rst low at a clock edge: FSM to IDLE, buffer emptied, page=0, wbuf_ovf=0, ext_req=0, ext_we=0, and latched data=0.
REQ-030 Fast array contents SHALL NOT be reset.
REQ-031 Reset during RREQ or DRAIN SHALL drop ext_req in the next cycle; any in-flight ext_ack arriving after reset SHALL be ignored.

Structure
REQ-032 A shared package SHALL hold the fast-region base/limit, PAGE_ADDR, SP_ADDR and the FSM state enum.
REQ-033 The posted-write buffer SHALL be sub-module mem_wbuf, a synchronous FIFO with full, empty and count outputs; the fast array and FSM stay in mem_responder.

Verification
REQ-034 Write 0xFFFF1005<=0x1234, then read the same address -> memReady=1 in the same cycle, memReadIn=0x1234.
REQ-035 Write 0xFFFF1010<=0xABCD -> page=0xABCD next cycle; a read of 0xFFFF1010 returns 0xABCD.
REQ-036 External read 0x00002000, ack 2 cycles after req, ext_rdata=0x5A5A -> memReady high 4 cycles after memRE, memReadIn=0x5A5A.
REQ-037 Post 3 writes, then an external read -> all 3 writes are seen on ext_* in order before the read's ext_req.
REQ-038 Post 5 writes with ext_ack held low -> the first 4 are buffered, the fifth is dropped, and wbuf_ovf=1 until reset.
REQ-039 Assert rst low during RREQ -> ext_req=0 next cycle, state IDLE, page=0; a late ext_ack does not produce memReady.
